// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } mc_state_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Occupancy timer for the multi-cycle execute unit: stalls E for MC_LAT-1 cycles, then pulses done.
module hazard_mc_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic kill,
  output logic stall,
  output logic done
);

  localparam bit          MultiCycle = (MC_LAT >= 2);
  localparam int unsigned CntW       = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MultiCycle ? MC_LAT - 2 : 32'd0);

  mc_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // stall/done depend on start in IDLE so the first cycle of an op is held immediately
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!MultiCycle) begin
            done = 1'b1;
          end else if (!kill) begin
            stall   = 1'b1;
            cnt_d   = CntInit;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CntW'(1);
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Five-stage RISC-V hazard controller: forwarding, load-use and multi-cycle stalls, flushes.
// Optional saturating stall/flush counters are built when HAZARD_PERF_EN is defined.
module riscv_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              McDoneE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic lw_stall;
  logic mc_stall;

  // M holds the younger result, so it wins over W
  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = FWD_W;
    end

    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = FWD_W;
    end
  end

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  hazard_mc_timer #(
    .MC_LAT(MC_LAT)
  ) u_mc_timer (
    .clk  (clk),
    .reset(reset),
    .start(McStartE),
    .kill (PCSrcE),
    .stall(mc_stall),
    .done (McDoneE)
  );

  assign StallF = lw_stall | mc_stall;
  assign StallD = lw_stall | mc_stall;
  assign StallE = mc_stall;
  assign FlushD = PCSrcE;
  // A held E register must not be bubbled
  assign FlushE = (lw_stall | PCSrcE) & ~mc_stall;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against an occupancy-based reference model (MC_LAT=4 and MC_LAT=1 instances).
module tb_riscv_hazard_ctrl;

  localparam int unsigned AW     = 5;
  localparam int unsigned CW     = 4;
  localparam int          Lat    = 4;
  localparam int          CntMax = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, PCSrcE, McStartE;
  logic [1:0]    ResultSrcE;

  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, McDoneE;
  logic [CW-1:0] StallCnt, FlushCnt;

  logic [1:0]    o1_ForwardAE, o1_ForwardBE;
  logic          o1_StallF, o1_StallD, o1_StallE, o1_FlushD, o1_FlushE, o1_McDoneE;
  logic [CW-1:0] o1_StallCnt, o1_FlushCnt;

  int checks = 0;
  int errors = 0;
  // Reference state: cycles already spent in the current op (0 = no op), and event counts
  int age4, age1;
  int scnt_m, fcnt_m;

  always #5 clk = ~clk;

  riscv_hazard_ctrl #(.REG_AW(AW), .MC_LAT(Lat), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .McDoneE(McDoneE), .StallCnt(StallCnt),
    .FlushCnt(FlushCnt)
  );

  riscv_hazard_ctrl #(.REG_AW(AW), .MC_LAT(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE), .ForwardAE(o1_ForwardAE),
    .ForwardBE(o1_ForwardBE), .StallF(o1_StallF), .StallD(o1_StallD), .StallE(o1_StallE),
    .FlushD(o1_FlushD), .FlushE(o1_FlushE), .McDoneE(o1_McDoneE), .StallCnt(o1_StallCnt),
    .FlushCnt(o1_FlushCnt)
  );

  always @(posedge clk) begin
    if (reset) begin
      assert (!(McStartE && (PCSrcE || ResultSrcE == 2'b01)))
        else $error("illegal McStartE combination at %0t", $time);
    end
  end

  typedef struct {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic          rwm, rww;
    logic [1:0]    rsrc;
    logic          pc;
    logic [1:0]    fa, fb;
    logic          st, fd, fe;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // An op spends lat cycles in E: the first lat-1 stall, the last signals done
  task automatic mc_ref(input int lat, input int age, output bit stall, output bit done);
    if (age == 0) begin
      stall = McStartE && !PCSrcE && lat >= 2;
      done  = McStartE && lat == 1;
    end else begin
      stall = age < lat - 1;
      done  = age == lat - 1;
    end
  endtask

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, McStartE} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic model_reset();
    age4 = 0; age1 = 0; scnt_m = 0; fcnt_m = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Called mid-cycle: compare against the model, then advance one clock.
  task automatic sample_and_step();
    bit s4, d4, s1, d1, lw, fe;
    mc_ref(Lat, age4, s4, d4);
    mc_ref(1, age1, s1, d1);
    lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    fe = (lw | PCSrcE) & !s4;
    check("fwdA", ForwardAE, fwd_ref(Rs1E));
    check("fwdB", ForwardBE, fwd_ref(Rs2E));
    check("stallFDE", {StallF, StallD, StallE}, {lw | s4, lw | s4, s4});
    check("flushDE", {FlushD, FlushE}, {PCSrcE, fe});
    check("done", McDoneE, d4);
    check("stall_cnt", StallCnt, PerfEn ? scnt_m : 0);
    check("flush_cnt", FlushCnt, PerfEn ? fcnt_m : 0);
    check("lat1 stall_done", {o1_StallF, o1_StallE, o1_McDoneE}, {lw | s1, s1, d1});
    @(posedge clk);
    age4 = s4 ? age4 + 1 : 0;
    age1 = s1 ? age1 + 1 : 0;
    if (lw | s4) scnt_m = (scnt_m < CntMax) ? scnt_m + 1 : CntMax;
    if (PCSrcE | fe) fcnt_m = (fcnt_m < CntMax) ? fcnt_m + 1 : CntMax;
    #1;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0};
    tbl[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0};
    tbl[3]  = '{0, 0, 4, 3, 0, 4, 3, 1, 1, 2'b00, 0, 2'b10, 2'b01, 0, 0, 0};
    tbl[4]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0};
    tbl[6]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0};
    tbl[7]  = '{9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 1};
    tbl[9]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0};
    tbl[10] = '{0, 0, 6, 6, 0, 6, 0, 1, 0, 2'b00, 0, 2'b10, 2'b10, 0, 0, 0};
    tbl[11] = '{0, 0, 6, 6, 0, 0, 6, 0, 1, 2'b00, 0, 2'b01, 2'b01, 0, 0, 0};

    idle_inputs();
    model_reset();
    reset = 1'b0;
    #2;
    check("reset outputs", {StallF, StallD, StallE, FlushD, FlushE, McDoneE}, 0);
    check("reset counters", {StallCnt, FlushCnt}, 0);
    do_reset();
    #3 sample_and_step();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
      ResultSrcE = tbl[i].rsrc; PCSrcE = tbl[i].pc; McStartE = 1'b0;
      #3;
      check($sformatf("vec%0d fwdA", i), ForwardAE, tbl[i].fa);
      check($sformatf("vec%0d fwdB", i), ForwardBE, tbl[i].fb);
      check($sformatf("vec%0d stallFD", i), {StallF, StallD}, {tbl[i].st, tbl[i].st});
      check($sformatf("vec%0d flushDE", i), {FlushD, FlushE}, {tbl[i].fd, tbl[i].fe});
      sample_and_step();
    end

    // Two back-to-back MC_LAT=4 ops: stall 1,1,1,0 with done on the 4th cycle, twice
    idle_inputs();
    McStartE = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #3;
      check($sformatf("mc cyc%0d StallE", c), StallE, (c % 4) != 3);
      check($sformatf("mc cyc%0d done", c), McDoneE, (c % 4) == 3);
      check($sformatf("lat1 cyc%0d done", c), {o1_McDoneE, o1_StallF}, 2'b10);
      sample_and_step();
    end
    McStartE = 1'b0;
    #3 sample_and_step();

    // Reset in the second BUSY cycle aborts the op
    McStartE = 1'b1;
    #3 sample_and_step();
    McStartE = 1'b0;
    #2;
    check("busy before reset", StallE, 1);
    reset = 1'b0;
    #1;
    check("async abort stalls", {StallF, StallD, StallE}, 0);
    check("async abort done", McDoneE, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      check("no done after abort", McDoneE, 0);
      sample_and_step();
    end

    // Stall counter saturation
    do_reset();
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    for (int c = 0; c < 20; c++) begin
      #3 sample_and_step();
    end
    idle_inputs();
    #3;
    check("stall_cnt saturated", StallCnt, PerfEn ? 15 : 0);
    sample_and_step();

    // Flush counter
    do_reset();
    PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3 sample_and_step();
    end
    idle_inputs();
    #3;
    check("flush_cnt after 3", FlushCnt, PerfEn ? 3 : 0);
    check("stall_cnt after flushes", StallCnt, 0);
    sample_and_step();

    // Randomized traffic over a small register range to provoke matches
    for (int c = 0; c < 400; c++) begin
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 7) == 0);
      McStartE = 1'b0;
      if (!PCSrcE && ResultSrcE != 2'b01) McStartE = ($urandom_range(0, 3) == 0);
      #3 sample_and_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Parametrised hazard controller for the five-stage RISC-V pipeline. It generalises the existing hazard unit with a configurable register-address width and a multi-cycle execute unit (mul/div) that holds the Execute stage for `MC_LAT` cycles. It also has optional stall/flush performance counters. It sits beside `controller` and `datapath` in the pipeline top and drives all forward, stall and flush controls.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `MC_LAT`, 4: multi-cycle op latency in E, in cycles; must be ≥1.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: clock. One clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `Rs1D`, `Rs2D` in REG_AW: Decode source registers.
- `Rs1E`, `Rs2E`, `RdE` in REG_AW: Execute registers.
- `RdM`, `RdW` in REG_AW: Memory and Writeback destination registers.
- `RegWriteM`, `RegWriteW` in 1: write enables.
- `ResultSrcE` in 2: value `2'b01` marks a load in E.
- `PCSrcE` in 1: taken branch or jump resolved in E.
- `McStartE` in 1: the E instruction is a multi-cycle op.
- `ForwardAE`, `ForwardBE` out 2: `00` register file, `01` W result, `10` M ALU result.
- `StallF`, `StallD`, `StallE` out 1: hold pipeline registers.
- `FlushD`, `FlushE` out 1: bubble the D or E register.
- `McDoneE` out 1: one-cycle pulse; the multi-cycle result is valid in E.
- `StallCnt`, `FlushCnt` out CNT_W: performance counters.

## Operation
- **Forwarding (combinational), per source A/B:**
  - `10` if `RegWriteM` and `RdM != 0` and `RdM == RsxE`.
  - Otherwise `01` if `RegWriteW` and `RdW != 0` and `RdW == RsxE`.
  - Otherwise `00`. M has priority over W.
- **Load-use:** `lwStall = (ResultSrcE == 01) & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)`.
- **Multi-cycle FSM, states IDLE and BUSY, 0..MC_LAT-2 down-counter `cnt`:**
  - In IDLE with `McStartE`, `MC_LAT ≥ 2` and `!PCSrcE`: `mcStall = 1`, load `cnt = MC_LAT-2`, go to BUSY.
  - In IDLE with `McStartE` and `MC_LAT == 1`: no stall; `McDoneE = 1` that cycle.
  - In BUSY with `cnt != 0`: `mcStall = 1`, decrement `cnt`.
  - In BUSY with `cnt == 0`: `mcStall = 0`, `McDoneE = 1`, return to IDLE.
  - `McStartE` is ignored in BUSY, since it is the same instruction still held.
- **Stall and flush outputs:**
  - `StallF = StallD = lwStall | mcStall`.
  - `StallE = mcStall`.
  - `FlushD = PCSrcE`.
  - `FlushE = (lwStall | PCSrcE) & !mcStall`. A stall has priority over a flush of a held E.
- **Exclusivity:** `McStartE` with `PCSrcE`, and `McStartE` with a load in E, are illegal. The bench asserts this.
- **Counters (when compiled in):**
  - `StallCnt` increments every cycle in which `StallF` is high.
  - `FlushCnt` increments every cycle in which `FlushD` or `FlushE` is high.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (async, `reset == 0`): FSM to IDLE, `cnt = 0`, both counters 0, `McDoneE = 0`. All combinational outputs then follow their inputs; with idle inputs they are 0.
- Reset asserted in BUSY aborts the op immediately; no `McDoneE` pulse.
- A multi-cycle op occupies E for exactly `MC_LAT` cycles. `StallF/D/E` are high for the first `MC_LAT-1` cycles; `McDoneE` is high in the last cycle.
- A new `McStartE` is accepted on the cycle after `McDoneE`, so back-to-back multi-cycle ops have no idle gap.
- Load-use stall lasts 1 cycle; `FlushE` is high in that same cycle.
- Counters update on the `clk` rising edge, so their outputs lag the event by 1 cycle.

## Configuration
- `HAZARD_PERF_EN` defined: `StallCnt` and `FlushCnt` registers are present as above.
- `HAZARD_PERF_EN` undefined: no counter flops; `StallCnt` and `FlushCnt` are tied to 0. The port list is unchanged.

## Structure
- Package `hazard_pkg`:
  - `FWD_RF`, `FWD_W`, `FWD_M` 2-bit constants.
  - `RESULT_SRC_LOAD = 2'b01`.
  - `mc_state_t` enum {IDLE, BUSY}.
- Sub-module `hazard_mc_timer`: holds the FSM and `cnt`. Parameter `MC_LAT`; inputs `clk`, `reset`, `start`, `kill` (= `PCSrcE`); outputs `stall`, `done`.
- Top `riscv_hazard_ctrl`: contains the forwarding/load-use logic, the output combining, and the counters.

## Test plan
- `RdM = 5`, `RegWriteM = 1`, `RdW = 5`, `RegWriteW = 1`, `Rs1E = 5` → `ForwardAE = 10`. Then `RegWriteM = 0` → `01`. Then `RdM = RdW = 0`, `Rs1E = 0` → `00`.
- `ResultSrcE = 01`, `RdE = 7`, `Rs2D = 7` → `StallF = StallD = FlushE = 1` for 1 cycle. Repeat with `RdE = 0` → no stall.
- `MC_LAT = 4`, pulse `McStartE` → stalls high for 3 cycles and `McDoneE` on the 4th. A second `McStartE` on the next cycle → the same 3-stall/done pattern again.
- `MC_LAT = 1`, `McStartE` → `McDoneE = 1` in the same cycle, no stall.
- Drive `reset` low in the 2nd BUSY cycle → stalls drop asynchronously, FSM returns to IDLE, no `McDoneE`.
- With `HAZARD_PERF_EN` and `CNT_W = 4`, 20 stall cycles → `StallCnt = 15` (saturated). `PCSrcE` for 3 cycles → `FlushCnt = 3`. Without the macro, both read 0.
